// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..v-1, never less than one bit.
    function automatic int cnt_width(input int v);
        int w;
        w = 1;
        while ((64'd1 << w) < 64'(v)) w++;
        return w;
    endfunction

endpackage

// File: rtl/counter_n_bit_mod_if.sv
// Control and status bundle between a counter user (master) and the counter (slave).
interface counter_n_bit_mod_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (output en, up, load, load_val, input count, tc, wrap);
    modport slave  (input en, up, load, load_val, output count, tc, wrap);
endinterface

// File: rtl/counter_n_bit_mod_tick_divider.sv
// Enable-gated prescaler: emits one tick every PRESCALE enabled cycles.
module tick_divider
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            PW   = cnt_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign tick = en && (pre_q == LAST);

    // Phase holds while en is low so a paused count resumes where it left off.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end
endmodule

// File: rtl/counter_n_bit_mod.sv
// Up/down modulo counter with synchronous load, enable, prescaler and wrap/saturate mode.
module counter_n_bit_mod
    import counter_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MODULUS   = 8,
    parameter int SATURATE  = 0,
    parameter int RESET_VAL = 0,
    parameter int PRESCALE  = 1
) (
    input logic                clk,
    input logic                rst,
    counter_n_bit_mod_if.slave bus
);
    if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_modulus
        $fatal(1, "counter_n_bit_mod: MODULUS out of range 2..2^WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $fatal(1, "counter_n_bit_mod: RESET_VAL must be below MODULUS");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "counter_n_bit_mod: PRESCALE must be at least 1");
    end

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

    // One extra bit so MODULUS = 2^WIDTH compares exactly.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return ({1'b0, v} < MOD_X) ? v : LAST;
    endfunction

    // Returns {wrap, next_count}; boundaries are explicit, never natural overflow.
    function automatic logic [WIDTH:0] step_val(input logic [WIDTH-1:0] c, input logic dir);
        logic             w;
        logic [WIDTH-1:0] n;
        w = 1'b0;
        n = c;
        if (dir == DIR_UP) begin
            if (c != LAST)          n = c + WIDTH'(1);
            else if (SATURATE == 0) begin n = '0;   w = 1'b1; end
        end else begin
            if (c != '0)            n = c - WIDTH'(1);
            else if (SATURATE == 0) begin n = LAST; w = 1'b1; end
        end
        return {w, n};
    endfunction

    logic             tick;
    logic [WIDTH-1:0] count_q, count_n;
    logic             wrap_q, wrap_n;

    tick_divider #(.PRESCALE(PRESCALE)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .en   (bus.en),
        .tick (tick)
    );

    always_comb begin
        count_n = count_q;
        wrap_n  = 1'b0;
        if (bus.load) begin
            count_n = clamp_load(bus.load_val);
        end else if (tick) begin
            {wrap_n, count_n} = step_val(count_q, bus.up);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_C;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_n;
            wrap_q  <= wrap_n;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc    = (bus.up == DIR_UP) ? (count_q == LAST) : (count_q == '0);
endmodule

// File: doc/counter_n_bit_mod.md
# counter_n_bit_mod

Parametrised up/down modulo counter with synchronous load, enable, optional prescaler, and wrap or saturate mode. It is the general-purpose successor to the fixed 3-bit free-running counter. Defaults reproduce 3-bit, modulo-8, count-up behaviour. It serves as the timebase and event counter for downstream tutorial blocks (dividers, sequencers, timers).

## Interface
Parameters:
- WIDTH, 3: count register width.
- MODULUS, 8: count range 0..MODULUS-1. Legal when 2 <= MODULUS <= 2^WIDTH.
- SATURATE, 0: 0 wraps at the boundary; 1 holds at the boundary.
- RESET_VAL, 0: count value after reset. Must be < MODULUS.
- PRESCALE, 1: number of enabled cycles per count step. Must be >= 1.

Ports:
- clk  in  1  Single clock, rising edge.
- rst  in  1  Reset, synchronous and active-high.
- en  in  1  Count enable. Gates both the prescaler and the step.
- up  in  1  Direction: 1 counts up, 0 counts down.
- load  in  1  Synchronous load request.
- load_val  in  WIDTH  Value to load.
- count  out  WIDTH  Current count (registered).
- tc  out  1  Terminal count (combinational from count and up).
- wrap  out  1  One-cycle registered pulse on an actual wrap.

## Operation
- Priority per clock edge: rst > load > step > hold.
- Reset: count = RESET_VAL, wrap = 0, prescaler count = 0.
- Load:
  - count = load_val when load_val < MODULUS; otherwise count = MODULUS-1 (clamped).
  - Prescaler clears to 0. wrap = 0.
  - en is ignored in a load cycle.
- Prescaler:
  - pre_cnt advances only when en=1.
  - tick = en && (pre_cnt == PRESCALE-1). pre_cnt returns to 0 on tick.
  - With PRESCALE=1, tick = en.
  - When en=0, pre_cnt holds.
- Step (tick=1, no rst or load):
  - Up, count < MODULUS-1: count+1.
  - Up, count == MODULUS-1: 0 when SATURATE=0 (wrap=1 next cycle); hold when SATURATE=1 (wrap=0).
  - Down, count > 0: count-1.
  - Down, count == 0: MODULUS-1 when SATURATE=0 (wrap=1); hold when SATURATE=1 (wrap=0).
- Arithmetic: compute in WIDTH bits. Boundary compare against MODULUS-1 must be exact, with no reliance on natural overflow. MODULUS = 2^WIDTH must still wrap correctly.
- tc = up ? (count == MODULUS-1) : (count == 0). tc responds to a change of up in the same cycle.
- wrap is high for exactly one cycle after a wrapping step; otherwise 0.
- A direction change takes effect on the next tick. No prescaler reset.

## Timing
- All outputs except tc are registered. count changes one clk after the qualifying edge.
- Latency: rst, load, or tick sampled at edge N gives the new count visible after edge N.
- The first step after reset occurs PRESCALE enabled cycles after rst deasserts.
- Reset mid-count overrides load and step in the same cycle. The prescaler phase is lost.
- load and tick coincident: the load wins and the pending tick is discarded.
- Continuous en=1, wrap mode, PRESCALE=P: wrap pulses every MODULUS*P cycles.

## Structure
- Shared package counter_pkg holds:
  - constants DIR_UP=1'b1 and DIR_DOWN=1'b0;
  - a clog2-style width function for prescaler sizing (minimum 1 bit).
- Sub-module tick_divider: parameter PRESCALE; ports clk, rst, clr, en, tick. The counter drives clr from load.
- Parameter legality is checked at elaboration. An illegal MODULUS, RESET_VAL or PRESCALE raises a fatal error.

## Test plan
- Defaults, rst high for 1 cycle, then en=1, up=1 for 10 cycles:
  - count sequence 0,1,…,7,0,1.
  - wrap high exactly one cycle, after 7→0.
  - tc high while count=7.
- MODULUS=6, up=0, RESET_VAL=2, en=1: count 2,1,0,5,4. wrap pulses after 0→5; tc high at 0.
- MODULUS=6, SATURATE=1, up=1 from 3, en=1 for 6 cycles: count 4,5,5,5,5,5. wrap never asserts. tc stays high from the first 5.
- Defaults, load=1 with load_val=5 concurrent with en=1: count=5 with no extra step. Then MODULUS=6, load_val=7: count clamps to 5.
- PRESCALE=3, en=1 continuous: count steps every 3rd cycle. Dropping en for 2 cycles stretches the interval to 5 cycles with the phase held.
- rst asserted at count=4 concurrently with load=1: count=RESET_VAL next cycle, wrap=0, and the prescaler restarts from 0.
